// File: rtl/spi_xfer_engine.sv
// rtl/spi_xfer_engine.sv - SPI master shift engine with chip-select timing, bursts and RX backpressure
module spi_xfer_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int NSS_NUM    = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int DLY_WIDTH  = 8,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DLY_WIDTH-1:0]  cs_dly_i,
    input  logic [NSS_NUM-1:0]    nss_sel_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_last_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  sck_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
    output logic [NSS_NUM-1:0]    nss_o
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, GAP} state_t;

    localparam int CNT_WIDTH = LEN_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH - 1);

    state_t state, state_next;

    logic                  cfg_cpol, cfg_cpha, cfg_lsb, cfg_last;
    logic [DIV_WIDTH-1:0]  cfg_div, div_cnt;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic [DLY_WIDTH-1:0]  cfg_dly, dly_cnt;
    logic [CNT_WIDTH-1:0]  edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, tx_aligned, rx_next, rx_final, rx_word;

    logic rx_slot, hs, tick, dly_done, sck_edge, odd_edge, last_edge;
    logic frame_end, sample_now, present_now;

    function automatic logic cur_bit(input logic [DATA_WIDTH-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] sr, input logic lsb);
        return lsb ? (sr >> 1) : (sr << 1);
    endfunction

    assign rx_slot    = !rx_valid_o || rx_ready_i;
    assign tx_ready_o = en_i && !rst_i && (state == IDLE || state == NEXT) && rx_slot;
    assign hs         = tx_valid_i && tx_ready_o;
    assign busy_o     = (state != IDLE);

    assign tick     = (state != IDLE) && (div_cnt == cfg_div);
    assign dly_done = (dly_cnt == cfg_dly);
    // The final setup tick is also the first SCK edge, so setup spans exactly cs_dly+1 half-periods.
    assign sck_edge  = tick && (state == SHIFT || (state == SETUP && dly_done));
    assign odd_edge  = !edge_cnt[0];
    assign last_edge = (edge_cnt == {cfg_len, 1'b1});
    assign frame_end = sck_edge && last_edge;

    assign sample_now  = sck_edge && (odd_edge != cfg_cpha);
    assign present_now = sck_edge && !last_edge && (odd_edge == cfg_cpha);

    // MSB-first words are left-justified in the shifter so bit len leaves first.
    assign tx_aligned = lsb_i ? tx_data_i : (tx_data_i << (MAX_LEN - len_i));
    assign rx_next    = cfg_lsb ? {miso_i, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], miso_i};
    assign rx_final   = sample_now ? rx_next : rx_sr;
    assign rx_word    = cfg_lsb ? (rx_final >> (MAX_LEN - cfg_len)) : rx_final;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!en_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (hs) state_next = SETUP;
                SETUP:   if (sck_edge) state_next = SHIFT;
                SHIFT:   if (frame_end) state_next = cfg_last ? HOLD : NEXT;
                NEXT:    if (hs) state_next = SHIFT;
                HOLD:    if (tick && dly_done) state_next = GAP;
                GAP:     if (tick && dly_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_cpol   <= 1'b0;
            cfg_cpha   <= 1'b0;
            cfg_lsb    <= 1'b0;
            cfg_last   <= 1'b0;
            cfg_div    <= '0;
            cfg_len    <= '0;
            cfg_dly    <= '0;
            div_cnt    <= '0;
            dly_cnt    <= '0;
            edge_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            sck_o      <= 1'b0;
            mosi_o     <= 1'b0;
            nss_o      <= '1;
        end else if (!en_i) begin
            div_cnt    <= '0;
            rx_valid_o <= 1'b0;
            sck_o      <= cpol_i;
            nss_o      <= '1;
        end else begin
            if (state == IDLE || hs || tick) div_cnt <= '0;
            else                             div_cnt <= div_cnt + 1'b1;

            if (rx_ready_i) rx_valid_o <= 1'b0;

            case (state)
                IDLE:  sck_o <= cpol_i;
                SETUP: if (tick && !dly_done) dly_cnt <= dly_cnt + 1'b1;
                HOLD, GAP: begin
                    if (tick) dly_cnt <= dly_done ? '0 : dly_cnt + 1'b1;
                    if (state == HOLD && tick && dly_done) nss_o <= '1;
                end
                default: ;
            endcase

            if (hs) begin
                cfg_cpol <= cpol_i;
                cfg_cpha <= cpha_i;
                cfg_lsb  <= lsb_i;
                cfg_last <= tx_last_i;
                cfg_div  <= clk_div_i;
                cfg_len  <= len_i;
                cfg_dly  <= cs_dly_i;
                edge_cnt <= '0;
                dly_cnt  <= '0;
                rx_sr    <= '0;
                sck_o    <= cpol_i;
                if (state == IDLE) nss_o <= ~nss_sel_i;
                if (!cpha_i) begin
                    mosi_o <= cur_bit(tx_aligned, lsb_i);
                    tx_sr  <= advance(tx_aligned, lsb_i);
                end else begin
                    tx_sr  <= tx_aligned;
                end
            end

            if (sck_edge) begin
                sck_o    <= last_edge ? cfg_cpol : ~sck_o;
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (sample_now) rx_sr <= rx_next;
            if (present_now) begin
                mosi_o <= cur_bit(tx_sr, cfg_lsb);
                tx_sr  <= advance(tx_sr, cfg_lsb);
            end
            if (frame_end) begin
                rx_valid_o <= 1'b1;
                rx_data_o  <= rx_word;
                dly_cnt    <= '0;
            end
        end
    end
endmodule
